texture_link_tx: RTL

- Host-side transmitter for the texture-memory serial load link.
- Takes bytes over a valid/ready stream and drives the three link wires: `link_rst`, `link_clk`, `link_data`.
- The receiver treats every `link_clk` transition (either edge) as one bit, MSB first, and writes one byte per 8 bits.
- Used in bring-up harnesses and in a companion host design that loads textures into the BRAM bank.

---
 rtl/texture_link_tx.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/texture_link_tx.sv
// Serial transmitter for the texture-memory load link (link_rst / link_clk / link_data).
// Define TEXTURE_LINK_TX_FIFO_EN for a 4-entry input FIFO instead of a single holding register.
module texture_link_tx #(
  parameter int BIT_DIV    = 4,
  parameter int BYTE_GAP   = 8,
  parameter int RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_frame,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        link_rst,
  output logic        link_clk,
  output logic        link_data,
  output logic        busy,
  output logic [12:0] byte_count
);

  typedef enum logic [2:0] {S_IDLE, S_RSTP, S_LOAD, S_SETUP, S_EDGE, S_HOLD, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        link_rst_q, link_rst_d;
  logic        link_clk_q, link_clk_d;
  logic        link_data_q, link_data_d;
  logic [12:0] byte_count_q, byte_count_d;

  logic       push, pop, full, empty;
  logic [7:0] head;

  assign in_ready = !full && (state_q != S_RSTP) && !start_frame;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == S_LOAD) && !start_frame;

`ifdef TEXTURE_LINK_TX_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [7:0] fifo_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (start_frame) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = in_data;
        wr_ptr_d         = wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full  = (count_q == 3'd4);
  assign empty = (count_q == 3'd0);
  assign head  = fifo_q[rd_ptr_q];
`else
  logic [7:0] hold_q, hold_d;
  logic       valid_q, valid_d;

  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    if (start_frame) begin
      valid_d = 1'b0;
    end else begin
      if (pop) valid_d = 1'b0;
      if (push) begin
        hold_d  = in_data;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  assign full  = valid_q;
  assign empty = !valid_q;
  assign head  = hold_q;
`endif

  // The EDGE cycle is the first hold cycle, so HOLD itself runs BIT_DIV-1 cycles.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    link_rst_d   = link_rst_q;
    link_clk_d   = link_clk_q;
    link_data_d  = link_data_q;
    byte_count_d = byte_count_q;
    if (start_frame) begin
      state_d      = S_RSTP;
      cnt_d        = 16'(RST_CYCLES - 1);
      link_rst_d   = 1'b1;
      link_clk_d   = 1'b0;
      byte_count_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (!empty) state_d = S_LOAD;
        S_RSTP: begin
          if (cnt_q == 16'd0) begin
            link_rst_d = 1'b0;
            state_d    = S_IDLE;
          end else cnt_d = cnt_q - 16'd1;
        end
        S_LOAD: begin
          shift_d     = head;
          idx_d       = 3'd7;
          link_data_d = head[7];
          cnt_d       = 16'(BIT_DIV - 1);
          state_d     = S_SETUP;
        end
        S_SETUP: begin
          if (cnt_q == 16'd0) begin
            link_clk_d = !link_clk_q;
            cnt_d      = 16'(BIT_DIV - 2);
            state_d    = S_EDGE;
          end else cnt_d = cnt_q - 16'd1;
        end
        S_EDGE: state_d = S_HOLD;
        S_HOLD: begin
          if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
          end else if (idx_q == 3'd0) begin
            byte_count_d = byte_count_q + 13'd1;
            cnt_d        = 16'(BYTE_GAP - 1);
            state_d      = S_GAP;
          end else begin
            idx_d       = idx_q - 3'd1;
            link_data_d = shift_q[idx_q - 3'd1];
            cnt_d       = 16'(BIT_DIV - 1);
            state_d     = S_SETUP;
          end
        end
        S_GAP: begin
          if (cnt_q == 16'd0) state_d = empty ? S_IDLE : S_LOAD;
          else                cnt_d   = cnt_q - 16'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      link_rst_q   <= 1'b0;
      link_clk_q   <= 1'b0;
      link_data_q  <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      link_rst_q   <= link_rst_d;
      link_clk_q   <= link_clk_d;
      link_data_q  <= link_data_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign link_rst   = link_rst_q;
  assign link_clk   = link_clk_q;
  assign link_data  = link_data_q;
  assign byte_count = byte_count_q;
  assign busy       = (state_q != S_IDLE) || !empty;

endmodule
